// File: rtl/ref_tick_pkg.sv
// ref_tick_pkg: shared FSM state type and minimum-period helper for the reference tick multiplier.
package ref_tick_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_e;

    // Shortest period that still leaves room for MULT strobes and a full divide.
    function automatic int min_period(input int mult, input int period_w);
        return (mult > period_w + 2) ? mult : period_w + 2;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider by a constant, W-bit dividend, start/done handshake, W+1 cycle latency.
module seq_divider #(
    parameter int W       = 8,
    parameter int DIVISOR = 6
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] DIV = W'(DIVISOR);

    logic [W-1:0]  rem_q, quo_q, trial;
    logic [W:0]    shifted;
    logic [CW-1:0] cnt_q;
    logic          busy_q, take;

    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        take    = shifted >= {1'b0, DIV};
        trial   = shifted[W-1:0] - DIV;
    end

    // quotient_o only changes on completion so it stays usable while the next divide runs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_o     <= 1'b0;
            quotient_o <= '0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            cnt_q  <= CW'(W);
            busy_q <= 1'b1;
            done_o <= 1'b0;
        end else if (busy_q && cnt_q != '0) begin
            rem_q  <= take ? trial : shifted[W-1:0];
            quo_q  <= {quo_q[W-2:0], take};
            cnt_q  <= cnt_q - 1'b1;
            done_o <= 1'b0;
        end else if (busy_q) begin
            quotient_o <= quo_q;
            busy_q     <= 1'b0;
            done_o     <= 1'b1;
        end else begin
            done_o <= 1'b0;
        end
    end

endmodule

// File: rtl/ref_tick_multiplier.sv
// ref_tick_multiplier: measures a slow reference period and emits MULT evenly spaced,
// phase-aligned single-cycle strobes per reference period once the period is stable.
module ref_tick_multiplier
    import ref_tick_pkg::*;
#(
    parameter int MULT       = 6,
    parameter int PERIOD_W   = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ref,
    output logic                o_tick,
    output logic                o_locked,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_err
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int CW = $clog2(MULT);
    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(min_period(MULT, PERIOD_W));
    localparam logic [PERIOD_W-1:0] SAT    = '1;
    localparam logic [MW-1:0]       LOCK_N = MW'(LOCK_COUNT);
    localparam logic [CW-1:0]       LAST   = CW'(MULT - 1);

    state_e              state_q, state_d;
    logic                ref_q, step_ok_q, rise, sat, valid, consistent, timeout, gen;
    logic                div_start, div_done, strobe;
    logic [PERIOD_W-1:0] cnt_q, step_q, gap_q, step_next, diff;
    logic [MW-1:0]       match_q, match_inc, match_new;
    logic [CW-1:0]       left_q;

    always_comb begin
        rise       = i_ref & ~ref_q;
        sat        = cnt_q == SAT;
        valid      = cnt_q >= MIN_P && !sat;
        diff       = (cnt_q >= o_period) ? cnt_q - o_period : o_period - cnt_q;
        consistent = valid && diff <= PERIOD_W'(1);
        match_inc  = (match_q >= LOCK_N) ? LOCK_N : match_q + 1'b1;
        match_new  = !valid ? '0 : consistent ? match_inc : MW'(1);
        gen        = rise && ((state_q == LOCKED) ? consistent
                           : (state_q == ACQ && valid && match_new >= LOCK_N && step_ok_q));
        timeout    = sat && !rise && state_q != IDLE;
        div_start  = rise && valid && state_q != IDLE;
        state_d    = timeout ? IDLE : !rise ? state_q : (state_q == IDLE) ? ACQ : gen ? LOCKED : ACQ;
        strobe     = state_d == LOCKED && left_q != '0 && gap_q == step_q;
    end

    seq_divider #(.W(PERIOD_W), .DIVISOR(MULT)) u_div (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .start_i    (div_start),
        .dividend_i (cnt_q),
        .done_o     (div_done),
        .quotient_o (step_next)
    );

    // step_ok_q marks that step_next holds the quotient of the period just before the current one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ref_q     <= 1'b0;
            cnt_q     <= '0;
            match_q   <= '0;
            step_ok_q <= 1'b0;
            step_q    <= '0;
            gap_q     <= '0;
            left_q    <= '0;
            o_tick    <= 1'b0;
            o_locked  <= 1'b0;
            o_period  <= '0;
            o_err     <= 1'b0;
        end else begin
            ref_q     <= i_ref;
            cnt_q     <= rise ? PERIOD_W'(1) : sat ? cnt_q : cnt_q + 1'b1;
            state_q   <= state_d;
            o_locked  <= state_d == LOCKED;
            o_err     <= timeout || (rise && state_q != IDLE && !valid);
            step_ok_q <= (rise || timeout) ? 1'b0 : div_done ? 1'b1 : step_ok_q;
            if (rise && state_q != IDLE) begin
                o_period <= cnt_q;
                match_q  <= match_new;
            end else if (rise) begin
                match_q <= '0;
            end
            if (gen) begin
                step_q <= step_next;
                gap_q  <= PERIOD_W'(1);
                left_q <= LAST;
                o_tick <= 1'b1;
            end else if (strobe) begin
                gap_q  <= PERIOD_W'(1);
                left_q <= left_q - 1'b1;
                o_tick <= 1'b1;
            end else begin
                gap_q  <= gap_q + 1'b1;
                left_q <= (state_d == LOCKED) ? left_q : '0;
                o_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ref_tick_multiplier.sv
// tb_ref_tick_multiplier: directed and random reference periods checked against an event-level model.
module tb_ref_tick_multiplier;

    localparam int MULT  = 6;
    localparam int LC    = 2;
    localparam int MIN_P = 10;
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

    logic       clk = 1'b0;
    logic       i_rst_n, i_ref;
    logic       o_tick, o_locked, o_err;
    logic [7:0] o_period;

    int passed = 0, total = 0;
    int cyc = 0, last_r = 0, gen_r = 0, gen_step = 1, match = 0, exp_period = 0, step_val = 0;
    int mstate = M_IDLE, ticks = 0, errs = 0;
    bit ref_prev, step_avail, gen_on, exp_tick, exp_locked, exp_err, last_exp_tick, found;

    ref_tick_multiplier #(.MULT(MULT), .PERIOD_W(8), .LOCK_COUNT(LC)) dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_ref    (i_ref),
        .o_tick   (o_tick),
        .o_locked (o_locked),
        .o_period (o_period),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        mstate = M_IDLE; match = 0; exp_period = 0; step_avail = 0; gen_on = 0;
        ref_prev = 0; exp_tick = 0; exp_locked = 0; exp_err = 0;
    endtask

    // Event-level model: evaluated once per cycle, yields the outputs visible next cycle.
    task automatic model_step();
        bit rise, valid, cons;
        int el, p;
        if (!i_rst_n) begin
            model_reset();
            cyc++;
            return;
        end
        rise = i_ref && !ref_prev;
        ref_prev = i_ref;
        el = cyc - last_r;
        p = (el > 255) ? 255 : el;
        exp_err = 0;
        if (rise) begin
            if (mstate == M_IDLE) begin
                mstate = M_ACQ; match = 0; step_avail = 0;
            end else begin
                valid = p >= MIN_P && p < 255;
                cons = valid && (p - exp_period <= 1) && (exp_period - p <= 1);
                exp_err = !valid;
                if (mstate == M_ACQ) begin
                    match = !valid ? 0 : cons ? ((match + 1 > LC) ? LC : match + 1) : 1;
                    if (valid && match >= LC && step_avail) begin
                        mstate = M_LOCK; gen_on = 1; gen_r = cyc; gen_step = step_val;
                    end
                end else if (cons) begin
                    gen_r = cyc; gen_step = step_val;
                end else begin
                    mstate = M_ACQ; match = valid ? 1 : 0; gen_on = 0;
                end
                exp_period = p;
                step_avail = valid;
                step_val = p / MULT;
            end
            last_r = cyc;
        end else if (mstate != M_IDLE && el >= 255) begin
            exp_err = 1; mstate = M_IDLE; gen_on = 0;
        end
        exp_locked = mstate == M_LOCK;
        exp_tick = gen_on && ((cyc - gen_r) % gen_step == 0) && ((cyc - gen_r) / gen_step < MULT);
        cyc++;
    endtask

    task automatic cycle(input bit r);
        @(posedge clk);
        #1;
        chk("tick", o_tick, exp_tick);
        chk("locked", o_locked, exp_locked);
        chk("err", o_err, exp_err);
        chk("period", o_period, exp_period);
        if (o_tick === 1'b1) ticks++;
        if (o_err === 1'b1) errs++;
        last_exp_tick = exp_tick;
        i_ref = r;
        model_step();
    endtask

    task automatic period(input int p, input int hi);
        for (int i = 0; i < p; i++) cycle(i < hi);
    endtask

    initial begin
        int base, n, p;
        model_reset();
        i_rst_n = 0;
        i_ref = 0;
        for (int i = 0; i < 80; i++) cycle((i / 36) % 2 == 1);
        cycle(0);
        i_rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            ticks = 0;
            period(36, 18);
            if (i >= 2) chk("ticks36", ticks, 6);
        end
        chk("period36", o_period, 36);
        chk("locked36", o_locked, 1);
        for (int i = 0; i < 6; i++) period((i % 2 == 0) ? 37 : 36, 10);
        chk("locked_alt", o_locked, 1);
        for (int i = 0; i < 5; i++) begin
            ticks = 0;
            period(50, 25);
        end
        chk("ticks50", ticks, 6);
        chk("locked50", o_locked, 1);
        for (int i = 0; i < 5; i++) begin
            ticks = 0;
            period(38, 5);
        end
        chk("ticks38", ticks, 6);
        chk("period38", o_period, 38);
        errs = 0;
        ticks = 0;
        for (int i = 0; i < 300; i++) cycle(0);
        chk("timeout_errs", errs, 1);
        chk("timeout_locked", o_locked, 0);
        errs = 0;
        ticks = 0;
        for (int i = 0; i < 6; i++) period(8, 4);
        chk("short_errs", errs, 5);
        chk("short_ticks", ticks, 0);
        chk("short_locked", o_locked, 0);
        for (int s = 0; s < 6; s++) begin
            base = (s == 3) ? int'($urandom_range(4, 9)) : int'($urandom_range(10, 120));
            n = int'($urandom_range(3, 6));
            for (int j = 0; j < n; j++) begin
                p = base + int'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) p = p + 3;
                period(p, int'($urandom_range(1, p - 1)));
            end
        end
        for (int i = 0; i < 5; i++) period(40, 20);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(i < 20);
            if (last_exp_tick && o_tick === 1'b1) found = 1;
        end
        chk("found_tick", found, 1);
        #1;
        i_rst_n = 0;
        #1;
        chk("async_tick", o_tick, 0);
        chk("async_locked", o_locked, 0);
        chk("async_period", o_period, 0);
        model_reset();
        i_ref = 0;
        for (int i = 0; i < 3; i++) cycle(0);
        i_rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            ticks = 0;
            period(36, 18);
        end
        chk("recover_ticks", ticks, 6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
